// File: rtl/frame_mem_pkg.sv
// Shared types and defaults for the double-buffered LED frame memory.
package frame_mem_pkg;

  localparam int DEF_DATA_W = 24;
  localparam int DEF_CH     = 2;
  localparam int DEF_DEPTH  = 1024;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PENDING,
    ST_CLEAR
  } fb_state_e;

  // LSB position of channel c inside a packed multi-channel word
  function automatic int unsigned ch_lsb(input int unsigned c, input int unsigned w);
    return c * w;
  endfunction

endpackage

// File: rtl/frame_buffer_mem_dpram.sv
// Simple dual-port RAM: one write port, one read port with registered output.
module dpram_param #(
  parameter  int DATA_W = 24,
  parameter  int DEPTH2 = 2048,
  localparam int AW     = $clog2(DEPTH2)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH2];

  // Storage array write; contents are not reset
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port, holds its value while re is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/frame_buffer_mem.sv
// Double-buffered pixel memory: scanner reads front buffer, host writes back
// buffer, swaps are deferred to a scanner frame boundary, back buffer clearable.
module frame_buffer_mem
  import frame_mem_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int CH     = DEF_CH,
  parameter  int DEPTH  = DEF_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int CH_W   = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   rd_en,
  input  logic [ADDR_W-1:0]      rd_addr,
  output logic [CH*DATA_W-1:0]   rd_data,
  output logic                   rd_valid,
  input  logic                   wr_en,
  input  logic [CH_W+ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0]      wr_data,
  output logic                   wr_ready,
  input  logic                   swap_req,
  input  logic                   frame_end,
  output logic                   swap_ack,
  output logic                   front_buf,
  input  logic                   clear_req,
  output logic                   clear_busy
);

  fb_state_e         state;
  logic [ADDR_W-1:0] clr_cnt;
  logic              swap_latched;
  logic              clr_last;
  logic [CH_W-1:0]   wr_ch;
  logic [ADDR_W-1:0] wr_pix;
  logic [ADDR_W:0]   ram_waddr;
  logic [ADDR_W:0]   ram_raddr;
  logic [DATA_W-1:0] ram_wdata;
  logic [CH-1:0]     ram_we;

  assign wr_ready   = (state == ST_IDLE);
  assign clear_busy = (state == ST_CLEAR);
  assign clr_last   = (clr_cnt == ADDR_W'(DEPTH - 1));
  assign wr_ch      = wr_addr[ADDR_W +: CH_W];
  assign wr_pix     = wr_addr[ADDR_W-1:0];

  // Back-buffer port is shared by host writes and the clear engine
  assign ram_waddr = {~front_buf, clear_busy ? clr_cnt : wr_pix};
  assign ram_wdata = clear_busy ? '0 : wr_data;
  assign ram_raddr = {front_buf, rd_addr};

  // Swap/clear control; clear wins over a simultaneous swap, which is latched
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      front_buf    <= 1'b0;
      swap_ack     <= 1'b0;
      clr_cnt      <= '0;
      swap_latched <= 1'b0;
    end else begin
      swap_ack <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (clear_req) begin
            state        <= ST_CLEAR;
            clr_cnt      <= '0;
            swap_latched <= swap_req;
          end else if (swap_req && frame_end) begin
            front_buf <= ~front_buf;
            swap_ack  <= 1'b1;
          end else if (swap_req) begin
            state <= ST_PENDING;
          end
        end
        ST_PENDING: begin
          if (frame_end) begin
            front_buf <= ~front_buf;
            swap_ack  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        ST_CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_last) begin
            state        <= (swap_latched || swap_req) ? ST_PENDING : ST_IDLE;
            swap_latched <= 1'b0;
          end else if (swap_req) begin
            swap_latched <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Read-valid tracks the read strobe with one cycle of latency
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rd_valid <= 1'b0;
    else          rd_valid <= rd_en;
  end

  for (genvar c = 0; c < CH; c++) begin : g_ch
    localparam int LSB = ch_lsb(c, DATA_W);

    assign ram_we[c] = clear_busy || (wr_ready && wr_en && (wr_ch == CH_W'(c)));

    dpram_param #(
      .DATA_W (DATA_W),
      .DEPTH2 (2 * DEPTH)
    ) u_ram (
      .clk   (clk),
      .rst_n (reset_n),
      .we    (ram_we[c]),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .re    (rd_en),
      .raddr (ram_raddr),
      .rdata (rd_data[LSB +: DATA_W])
    );
  end

endmodule

// File: tb/tb_frame_buffer_mem.sv
// Directed self-checking bench for frame_buffer_mem (CH=3, DEPTH=16).
module tb_frame_buffer_mem;

  localparam int DATA_W = 24;
  localparam int CH     = 3;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int CH_W   = 2;

  logic                   clk = 1'b0;
  logic                   reset_n = 1'b0;
  logic                   rd_en = 1'b0;
  logic [ADDR_W-1:0]      rd_addr = '0;
  logic [CH*DATA_W-1:0]   rd_data;
  logic                   rd_valid;
  logic                   wr_en = 1'b0;
  logic [CH_W+ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0]      wr_data = '0;
  logic                   wr_ready;
  logic                   swap_req = 1'b0;
  logic                   frame_end = 1'b0;
  logic                   swap_ack;
  logic                   front_buf;
  logic                   clear_req = 1'b0;
  logic                   clear_busy;

  int checks = 0;
  int errors = 0;

  frame_buffer_mem #(
    .DATA_W (DATA_W),
    .CH     (CH),
    .DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .swap_req   (swap_req),
    .frame_end  (frame_end),
    .swap_ack   (swap_ack),
    .front_buf  (front_buf),
    .clear_req  (clear_req),
    .clear_busy (clear_busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [CH*DATA_W-1:0] obs,
                       input logic [CH*DATA_W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] slice(input int c);
    return rd_data[c*DATA_W +: DATA_W];
  endfunction

  task automatic host_write(input int ch, input int pix, input logic [DATA_W-1:0] d);
    wr_en   = 1'b1;
    wr_addr = {CH_W'(ch), ADDR_W'(pix)};
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic do_read(input int pix);
    rd_en   = 1'b1;
    rd_addr = ADDR_W'(pix);
    tick();
    rd_en   = 1'b0;
  endtask

  initial begin
    int busy_cycles;
    int ack_seen;

    // reset values
    #3;
    check("rst_front_buf", front_buf, 0);
    check("rst_swap_ack", swap_ack, 0);
    check("rst_clear_busy", clear_busy, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    reset_n = 1'b1;
    tick();
    check("rst_wr_ready", wr_ready, 1);

    // write, deferred swap, read back
    host_write(1, 5, 24'hA5A5A5);
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    check("pend_wr_ready", wr_ready, 0);
    check("pend_no_ack", swap_ack, 0);
    tick();
    tick();
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    check("swap_ack_pulse", swap_ack, 1);
    check("swap_front_1", front_buf, 1);
    check("swap_wr_ready", wr_ready, 1);
    tick();
    check("swap_ack_single", swap_ack, 0);
    do_read(5);
    check("rd_valid_1", rd_valid, 1);
    check("rd_ch1_pix5", slice(1), 24'hA5A5A5);
    tick();
    check("rd_valid_drop", rd_valid, 0);
    check("rd_hold", slice(1), 24'hA5A5A5);

    // clear back buffer (buf0), swap latched mid-clear, frame_end ignored in clear
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    busy_cycles = 0;
    ack_seen = 0;
    for (int i = 0; i < 24; i++) begin
      if (clear_busy) busy_cycles++;
      if (swap_ack) ack_seen++;
      swap_req  = (i == 3);
      frame_end = (i == 6);
      tick();
    end
    swap_req  = 1'b0;
    frame_end = 1'b0;
    check("clear_cycles", busy_cycles, 16);
    check("clear_no_ack", ack_seen, 0);
    check("clear_front_kept", front_buf, 1);
    check("clear_to_pending", wr_ready, 0);
    check("clear_busy_done", clear_busy, 0);
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    check("clr_swap_ack", swap_ack, 1);
    check("clr_swap_front_0", front_buf, 0);
    for (int p = 0; p < DEPTH; p++) begin
      do_read(p);
      check($sformatf("clr_pix%0d", p), rd_data, 0);
    end

    // writes dropped while swap pending
    host_write(0, 2, 24'h111111);
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    host_write(0, 2, 24'h222222);
    host_write(1, 5, 24'h333333);
    check("drop_wr_ready", wr_ready, 0);
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    check("drop_swap_ack", swap_ack, 1);
    check("drop_front_1", front_buf, 1);
    do_read(2);
    check("drop_ch0_pix2", slice(0), 24'h111111);
    do_read(5);
    check("drop_ch1_pix5", slice(1), 24'hA5A5A5);

    // out-of-range channel write, then immediate swap in IDLE
    host_write(3, 7, 24'hFFFFFF);
    swap_req  = 1'b1;
    frame_end = 1'b1;
    tick();
    swap_req  = 1'b0;
    frame_end = 1'b0;
    check("imm_swap_ack", swap_ack, 1);
    check("imm_front_0", front_buf, 0);
    check("imm_stay_idle", wr_ready, 1);
    do_read(7);
    check("badch_pix7", rd_data, 0);
    check("imm_ack_single", swap_ack, 0);

    // reset mid-PENDING with front_buf=1 and a read in flight
    swap_req  = 1'b1;
    frame_end = 1'b1;
    tick();
    swap_req  = 1'b0;
    frame_end = 1'b0;
    check("imm2_front_1", front_buf, 1);
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    check("pend2_wr_ready", wr_ready, 0);
    rd_en   = 1'b1;
    rd_addr = 4'd5;
    tick();
    check("pend2_rd_valid", rd_valid, 1);
    check("pend2_ch1_pix5", slice(1), 24'hA5A5A5);
    #2 reset_n = 1'b0;
    #1;
    check("arst_front_0", front_buf, 0);
    check("arst_swap_ack", swap_ack, 0);
    check("arst_rd_valid", rd_valid, 0);
    check("arst_rd_data", rd_data, 0);
    check("arst_wr_ready", wr_ready, 1);
    rd_en = 1'b0;
    #1 reset_n = 1'b1;
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    check("arst_no_swap_ack", swap_ack, 0);
    check("arst_no_swap_front", front_buf, 0);

    // reset mid-clear abandons the clear
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    tick();
    tick();
    check("clr2_busy", clear_busy, 1);
    #2 reset_n = 1'b0;
    #1;
    check("clr2_rst_busy", clear_busy, 0);
    check("clr2_rst_wr_ready", wr_ready, 1);
    #1 reset_n = 1'b1;
    tick();
    check("clr2_after_busy", clear_busy, 0);
    check("clr2_after_ready", wr_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_buffer_mem.md
# frame_buffer_mem

Parametrised double-buffered pixel memory between the host write interface and the LED panel scan engine. Holds CH independent channels (one per simultaneously driven row group), each with a front buffer read by the scanner and a back buffer written by the host. Buffer swaps are requested by the host and applied only at a scanner frame boundary, so the panel never shows a partially updated frame. A built-in clear engine can zero the back buffer.

## Interface
- DATA_W, 24, pixel word width (RGB888)
- CH, 2, number of channels (row groups)
- DEPTH, 1024, pixels per channel per buffer; power of two
- ADDR_W, clog2(DEPTH), localparam
- CH_W, max(1, clog2(CH)), localparam
- clk  in  1  single clock for all logic
- reset_n  in  1  asynchronous, active-low reset
- rd_en  in  1  scanner read strobe
- rd_addr  in  ADDR_W  pixel index, applied to all channels in parallel
- rd_data  out  CH*DATA_W  front-buffer words; channel c at bits [c*DATA_W +: DATA_W]
- rd_valid  out  1  rd_data holds the result of a read
- wr_en  in  1  host write strobe
- wr_addr  in  CH_W+ADDR_W  {channel, pixel index}
- wr_data  in  DATA_W  pixel word
- wr_ready  out  1  write accepted this cycle when high
- swap_req  in  1  single-cycle request to exchange front and back buffers
- frame_end  in  1  single-cycle pulse from scanner at end of frame
- swap_ack  out  1  single-cycle pulse, swap applied
- front_buf  out  1  index of the buffer currently read
- clear_req  in  1  single-cycle request to zero the back buffer
- clear_busy  out  1  clear in progress

## Operation
- Per channel RAM of 2*DEPTH words, address {buffer, pixel}. Reads use front_buf, writes and clears use ~front_buf.
- Write: accepted when wr_en && wr_ready; channel field selects the RAM; channel >= CH is dropped silently. Writes with wr_ready low are dropped.
- FSM states: IDLE, PENDING, CLEAR.
  - IDLE: wr_ready=1. swap_req -> PENDING. clear_req -> CLEAR (counter=0). swap_req && clear_req together: CLEAR, swap latched.
  - IDLE with swap_req && frame_end same cycle: swap applied immediately (front_buf toggles, swap_ack pulses), stay IDLE.
  - PENDING: wr_ready=0. On frame_end: toggle front_buf, pulse swap_ack, -> IDLE. Further swap_req ignored; clear_req ignored.
  - CLEAR: wr_ready=0, clear_busy=1; writes 0 to pixel counter in back buffer of every channel, counter +1 per cycle. After counter == DEPTH-1 written: -> PENDING if swap latched (swap_req arriving during CLEAR also latches), else IDLE. frame_end in CLEAR ignored.
- Reads unaffected by FSM state; rd_en always serviced.
- Reset (asynchronous, reset_n low): state IDLE, front_buf=0, swap_ack=0, clear_busy=0, wr_ready=1 after release, rd_valid=0, rd_data=0, counter=0, swap latch cleared. RAM contents undefined; a clear in progress is abandoned.

## Timing
- Read latency 1: rd_en/rd_addr sampled at edge N, rd_data/rd_valid valid after edge N+1; rd_valid = rd_en delayed one cycle; rd_data holds its value when rd_en low.
- Read sampled in the same cycle as an applied swap uses the old front_buf.
- front_buf and swap_ack update on the edge that samples frame_end; swap_ack high exactly one cycle.
- Write latency 1; a read of the same address in the back buffer is impossible by construction (reads only hit front).
- Clear takes exactly DEPTH cycles; clear_busy high from the edge after clear_req through the last clear write.
- wr_ready is combinational from state only (no dependence on wr_en).

## Structure
- Package frame_mem_pkg: FSM state enum, default DATA_W/CH/DEPTH constants, channel-slice helper function.
- Sub-module dpram_param (DATA_W, DEPTH2): simple dual-port RAM, one write port, one read port with registered output and rd_en; instantiated CH times via generate.
- Top holds FSM, clear counter, swap latch, write decode, rd_valid register.

## Test plan
- Reset, write 0xA5A5A5 to ch1 pix 5, swap_req, frame_end 3 cycles later -> swap_ack one cycle after frame_end edge, front_buf=1, read pix 5 -> ch1 slice 0xA5A5A5 one cycle after rd_en.
- swap_req then writes before frame_end -> wr_ready=0, writes dropped, post-swap read shows pre-request data only.
- swap_req and frame_end same cycle in IDLE -> swap_ack next cycle, no PENDING state visited.
- clear_req with DEPTH=16 -> clear_busy 16 cycles, after swap all reads return 0; swap_req during clear -> PENDING entered after clear, applied on next frame_end.
- Write to channel index CH (CH=3, CH_W=2) -> no RAM changes.
- reset_n asserted mid-clear and mid-PENDING -> all outputs at reset values immediately, front_buf=0, no swap_ack.
